// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router ingress controller
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    // Ingress sequencing states; all eight codes are used so no code is unreachable.
    typedef enum logic [2:0] {
        ST_DA  = 3'd0,  // decode header address
        ST_LFD = 3'd1,  // write header byte
        ST_LD  = 3'd2,  // stream payload
        ST_FFS = 3'd3,  // stalled on full FIFO
        ST_LAF = 3'd4,  // resume after full
        ST_LP  = 3'd5,  // write parity byte
        ST_CPE = 3'd6,  // parity check strobe
        ST_WTE = 3'd7   // wait for destination FIFO to drain
    } state_t;

    // Selects the per-port flag addressed by addr; the invalid address selects nothing.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] vec,
                                      input logic [ADDR_W-1:0]    addr);
        logic sel;
        sel = 1'b0;
        case (addr)
            2'd0:    sel = vec[0];
            2'd1:    sel = vec[1];
            2'd2:    sel = vec[2];
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return addr != INVALID_ADDR;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// rtl/router_fsm_if.sv - source/sync-side signals of the router ingress controller
interface router_fsm_if;
    import router_pkg::*;

    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;
    logic              parity_done;
    logic              low_pkt_valid;

    logic              busy;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic [ADDR_W-1:0] dest;

    // Environment side: drives packet/status inputs, observes controller outputs.
    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  busy, detect_add, lfd_state, ld_state, laf_state,
        input  full_state, write_enb_reg, rst_int_reg, dest
    );

    // Controller side.
    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output busy, detect_add, lfd_state, ld_state, laf_state,
        output full_state, write_enb_reg, rst_int_reg, dest
    );

endinterface

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet ingress sequencer for the 1x3 router
module router_fsm
    import router_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    router_fsm_if.slave  bus
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   dest_q;

    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 hdr_ok;
    logic                 soft_hit;

    assign fifo_empty = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_reset = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

    // A header is accepted only while decoding, with pkt_valid and a routable address.
    assign hdr_ok   = bus.pkt_valid && addr_ok(bus.data_in);

    // Only the port currently being written can abort the packet.
    assign soft_hit = port_sel(soft_reset, dest_q);

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_DA;
        end else begin
            state <= state_nxt;
        end
    end

    // Destination latch, loaded from the header during address decode.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dest_q <= '0;
        end else if (state == ST_DA && hdr_ok) begin
            dest_q <= bus.data_in;
        end
    end

    // Next-state logic; soft reset of the addressed port overrides everything.
    always_comb begin
        state_nxt = ST_DA;
        case (state)
            ST_DA: begin
                if (hdr_ok) begin
                    state_nxt = port_sel(fifo_empty, bus.data_in) ? ST_LFD : ST_WTE;
                end else begin
                    state_nxt = ST_DA;
                end
            end
            ST_LFD: begin
                state_nxt = ST_LD;
            end
            ST_LD: begin
                if (bus.fifo_full) begin
                    state_nxt = ST_FFS;
                end else if (!bus.pkt_valid) begin
                    state_nxt = ST_LP;
                end else begin
                    state_nxt = ST_LD;
                end
            end
            ST_FFS: begin
                state_nxt = bus.fifo_full ? ST_FFS : ST_LAF;
            end
            ST_LAF: begin
                if (bus.parity_done) begin
                    state_nxt = ST_DA;
                end else if (bus.low_pkt_valid) begin
                    state_nxt = ST_LP;
                end else begin
                    state_nxt = ST_LD;
                end
            end
            ST_LP: begin
                state_nxt = ST_CPE;
            end
            ST_CPE: begin
                state_nxt = bus.fifo_full ? ST_FFS : ST_DA;
            end
            ST_WTE: begin
                state_nxt = port_sel(fifo_empty, dest_q) ? ST_LFD : ST_WTE;
            end
            default: begin
                state_nxt = ST_DA;
            end
        endcase

        if (state != ST_DA && soft_hit) begin
            state_nxt = ST_DA;
        end
    end

    logic busy_o;
    logic detect_add_o;
    logic lfd_o;
    logic ld_o;
    logic laf_o;
    logic full_o;
    logic we_o;
    logic rst_int_o;

    // Moore output decode from the current state only.
    always_comb begin
        busy_o       = 1'b0;
        detect_add_o = 1'b0;
        lfd_o        = 1'b0;
        ld_o         = 1'b0;
        laf_o        = 1'b0;
        full_o       = 1'b0;
        we_o         = 1'b0;
        rst_int_o    = 1'b0;
        case (state)
            ST_DA: begin
                detect_add_o = 1'b1;
            end
            ST_LFD: begin
                lfd_o  = 1'b1;
                busy_o = 1'b1;
                we_o   = 1'b1;
            end
            ST_LD: begin
                ld_o = 1'b1;
                we_o = 1'b1;
            end
            ST_FFS: begin
                full_o = 1'b1;
                busy_o = 1'b1;
            end
            ST_LAF: begin
                laf_o  = 1'b1;
                busy_o = 1'b1;
                we_o   = 1'b1;
            end
            ST_LP: begin
                busy_o = 1'b1;
                we_o   = 1'b1;
            end
            ST_CPE: begin
                rst_int_o = 1'b1;
                busy_o    = 1'b1;
            end
            ST_WTE: begin
                busy_o = 1'b1;
            end
            default: begin
                detect_add_o = 1'b1;
            end
        endcase
    end

    assign bus.busy          = busy_o;
    assign bus.detect_add    = detect_add_o;
    assign bus.lfd_state     = lfd_o;
    assign bus.ld_state      = ld_o;
    assign bus.laf_state     = laf_o;
    assign bus.full_state    = full_o;
    assign bus.write_enb_reg = we_o;
    assign bus.rst_int_reg   = rst_int_o;
    assign bus.dest          = dest_q;

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - scoreboard bench for router_fsm
module tb_router_fsm;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    router_fsm_if bus ();

    router_fsm dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Stimulus variables applied by step().
    logic       pv, ff, pd, lpv;
    logic [1:0] din;
    logic [2:0] emp, sr;

    // Expected output bundle: {busy, detect_add, lfd, ld, laf, full, we, rst_int, dest[1:0]}.
    typedef struct {
        int         cyc;
        logic [9:0] vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int cnt_lfd, cnt_ld, cnt_we, cnt_wte, cnt_full;

    // Reference model: packet phase by name plus latched destination.
    string      m_state = "DA";
    logic [1:0] m_dest  = 2'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Output signature each phase must present.
    function automatic logic [7:0] outs_of(input string s);
        case (s)
            "DA":    return 8'b0100_0000;
            "LFD":   return 8'b1010_0010;
            "LD":    return 8'b0001_0010;
            "FFS":   return 8'b1000_0100;
            "LAF":   return 8'b1000_1010;
            "LP":    return 8'b1000_0010;
            "CPE":   return 8'b1000_0001;
            "WTE":   return 8'b1000_0000;
            default: return 8'hxx;
        endcase
    endfunction

    function automatic logic [9:0] dut_vec();
        return {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.dest};
    endfunction

    task automatic clear_counts();
        cnt_lfd = 0; cnt_ld = 0; cnt_we = 0; cnt_wte = 0; cnt_full = 0;
    endtask

    // Apply inputs, predict the post-edge response, advance one clock.
    task automatic step();
        string      n;
        logic [1:0] nd;
        bus.pkt_valid     = pv;
        bus.data_in       = din;
        bus.fifo_full     = ff;
        bus.fifo_empty_0  = emp[0];
        bus.fifo_empty_1  = emp[1];
        bus.fifo_empty_2  = emp[2];
        bus.soft_reset_0  = sr[0];
        bus.soft_reset_1  = sr[1];
        bus.soft_reset_2  = sr[2];
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;

        nd = m_dest;
        n  = m_state;
        if (!resetn) begin
            n  = "DA";
            nd = 2'd0;
        end else begin
            if (m_state == "DA" && pv && din != 2'd3) nd = din;
            case (m_state)
                "DA":  n = (pv && din != 2'd3) ? (emp[din] ? "LFD" : "WTE") : "DA";
                "LFD": n = "LD";
                "LD":  n = ff ? "FFS" : (!pv ? "LP" : "LD");
                "FFS": n = ff ? "FFS" : "LAF";
                "LAF": n = pd ? "DA" : (lpv ? "LP" : "LD");
                "LP":  n = "CPE";
                "CPE": n = ff ? "FFS" : "DA";
                "WTE": n = emp[m_dest] ? "LFD" : "WTE";
                default: n = "DA";
            endcase
            if (m_state != "DA" && sr[m_dest]) n = "DA";
        end
        exp_q.push_back('{cyc + 1, {outs_of(n), nd}});

        @(posedge clock);
        #1;
        m_state = n;
        m_dest  = nd;
        if (bus.lfd_state)     cnt_lfd++;
        if (bus.ld_state)      cnt_ld++;
        if (bus.write_enb_reg) cnt_we++;
        if (bus.full_state)    cnt_full++;
        if (bus.busy && !bus.write_enb_reg && !bus.full_state && !bus.rst_int_reg) cnt_wte++;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Monitor: compares every prediction whose clock edge has passed.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check($sformatf("cycle %0d outputs", mon_e.cyc), {22'd0, dut_vec()}, {22'd0, mon_e.vec});
        end
    end

    initial begin
        pv = 0; ff = 0; pd = 0; lpv = 0; din = 0; emp = 3'b111; sr = 3'b000;
        #1;
        check("reset outputs", {22'd0, dut_vec()}, {22'd0, 8'b0100_0000, 2'b00});
        steps(2);
        resetn = 1'b1;

        // Header addr 0, 14 LD cycles, parity.
        clear_counts();
        pv = 1; din = 2'd0; step();
        step();
        steps(13);
        pv = 0; step();
        steps(2);
        check("s1 lfd cycles", cnt_lfd, 1);
        check("s1 ld cycles", cnt_ld, 14);
        check("s1 writes", cnt_we, 16);
        check("s1 dest", {30'd0, bus.dest}, 0);
        check("s1 back in DA", {31'd0, bus.detect_add}, 1);

        // Header addr 1 waits for FIFO 1 to drain.
        clear_counts();
        emp = 3'b101; pv = 1; din = 2'd1; step();
        steps(4);
        check("s2 wte cycles", cnt_wte, 5);
        emp = 3'b111; step();
        check("s2 lfd after empty", {31'd0, bus.lfd_state}, 1);
        step();
        pv = 0; step();
        steps(2);

        // Full at payload byte 6, resume, 16 writes in total.
        clear_counts();
        pv = 1; din = 2'd2; step();
        step();
        steps(4);
        ff = 1; steps(3);
        ff = 0; step();
        step();
        steps(7);
        pv = 0; step();
        steps(2);
        check("s3 writes", cnt_we, 16);
        check("s3 full cycles", cnt_full, 3);

        // pkt_valid falls while stalled on full.
        pv = 1; din = 2'd0; step();
        step();
        step();
        ff = 1; step();
        pv = 0; lpv = 1; step();
        ff = 0; step();
        step();
        lpv = 0; step();
        step();

        // Invalid address is dropped, next header accepted.
        clear_counts();
        pv = 1; din = 2'd3; steps(2);
        check("s5 no writes", cnt_we, 0);
        din = 2'd2; step();
        check("s5 accept addr2", {31'd0, bus.lfd_state}, 1);
        step();
        pv = 0; step();
        steps(2);

        // Soft reset: non-addressed port ignored, addressed port aborts.
        pv = 1; din = 2'd2; step();
        step();
        sr = 3'b001; step();
        check("soft reset other port", {31'd0, bus.ld_state}, 1);
        sr = 3'b100; step();
        check("soft reset own port", {31'd0, bus.detect_add}, 1);
        sr = 3'b000;

        // Asynchronous reset mid-LD.
        pv = 1; din = 2'd1; step();
        steps(3);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("async reset outputs", {22'd0, dut_vec()}, {22'd0, 8'b0100_0000, 2'b00});
        m_state = "DA";
        m_dest  = 2'd0;
        @(posedge clock);
        #1;
        step();
        resetn = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pv  = ($urandom_range(0, 3) != 0);
            din = 2'($urandom_range(0, 3));
            ff  = ($urandom_range(0, 4) == 0);
            emp = 3'($urandom_range(0, 7));
            sr  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            pd  = ($urandom_range(0, 7) == 0);
            lpv = ($urandom_range(0, 3) == 0);
            step();
        end

        @(negedge clock);
        #1;
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Packet-ingress controller for the 1x3 router. It decodes the 2-bit destination in the header byte and sequences writes into the three router_fifo instances by driving write_enb_reg, lfd_state, ld_state and busy. It handles FIFO-full back-pressure, parity-byte capture, and per-port soft reset. It sits between the source interface and the sync/register blocks that route write enables and data to the FIFOs.

Parameters:
None. Three destinations are fixed by the 2-bit header address; address 2'b11 is invalid.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source asserts for header+payload; deasserts on parity byte
data_in  in  2  header address bits [1:0], valid when pkt_valid in DECODE_ADDRESS
fifo_full  in  1  full flag of currently addressed FIFO (muxed by sync block)
fifo_empty_0/1/2  in  1 each  empty flags of FIFOs 0..2
soft_reset_0/1/2  in  1 each  per-FIFO soft reset (timeout from sync block)
parity_done  in  1  register block has captured parity byte
low_pkt_valid  in  1  pkt_valid fell while FIFO was full
busy  out  1  source must hold current byte
detect_add  out  1  header decode cycle
lfd_state  out  1  header byte being written (drives FIFO lfd_state)
ld_state  out  1  payload load
laf_state  out  1  load-after-full
full_state  out  1  stalled on full FIFO
write_enb_reg  out  1  write enable toward FIFO demux
rst_int_reg  out  1  parity-check strobe
dest  out  2  latched destination address

Behaviour:
- State register updates on posedge clock; all outputs are Moore-decoded from state only. dest is registered.
- resetn=0 (async): state=DECODE_ADDRESS, dest=0. Outputs during reset: detect_add=1, all other outputs 0.
- dest <= data_in when state==DECODE_ADDRESS && pkt_valid && data_in!=3.
- DECODE_ADDRESS (DA), outputs detect_add=1:
  - pkt_valid && addr k<3 && fifo_empty_k -> LOAD_FIRST_DATA.
  - pkt_valid && addr k<3 && !fifo_empty_k -> WAIT_TILL_EMPTY.
  - addr==3 or !pkt_valid -> stay in DA; packet is dropped, no write.
- LOAD_FIRST_DATA (LFD), outputs lfd_state=1, busy=1, write_enb_reg=1 -> LOAD_DATA unconditionally. This is one cycle and writes the header.
- LOAD_DATA (LD), outputs ld_state=1, write_enb_reg=1, busy=0:
  - fifo_full -> FIFO_FULL_STATE (takes priority).
  - else !pkt_valid -> LOAD_PARITY.
  - else stay in LD.
- FIFO_FULL_STATE (FFS), outputs full_state=1, busy=1, write_enb_reg=0: !fifo_full -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL (LAF), outputs laf_state=1, busy=1, write_enb_reg=1:
  - parity_done -> DA.
  - else low_pkt_valid -> LOAD_PARITY.
  - else LD.
- LOAD_PARITY (LP), outputs busy=1, write_enb_reg=1 -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR (CPE), outputs rst_int_reg=1, busy=1: fifo_full -> FFS, else DA.
- WAIT_TILL_EMPTY (WTE), outputs busy=1, write_enb_reg=0: fifo_empty[dest] -> LFD, else stay.
- Soft reset: if soft_reset_k && dest==k && state!=DA, next state=DA. This overrides every other transition. A soft reset on a non-addressed port has no effect.
- Simultaneous events: in LD, full beats end-of-packet. In LAF, parity_done beats low_pkt_valid.
- Reset mid-packet: immediate return to DA. The partial packet stays in the FIFO; the FIFO's own reset or soft reset clears it.
- One-hot and binary encodings are both legal. An illegal state decodes to DA on the next clock.

Decomposition:
- Shared package router_pkg holds:
  - state enum/localparams (DA, LFD, LD, FFS, LAF, LP, CPE, WTE);
  - ADDR_W=2, NUM_PORTS=3, INVALID_ADDR=2'b11.
- No sub-module: the next-state logic, dest register and output decode sit in one module. The soft-reset timeout counters stay in router_sync.

Test Plan:
- Reset, then header 0x38 (len 14, addr 0) with fifo_empty_0=1 -> DA, LFD, then 14 cycles LD with write_enb_reg=1, then LP, CPE, DA. lfd_state high exactly 1 cycle; dest=0.
- Header addr 1 with fifo_empty_1=0 for 5 cycles -> WTE with busy=1, write_enb_reg=0 for 5 cycles; enters LFD the cycle after fifo_empty_1 rises.
- fifo_full=1 at payload byte 6 -> FFS with busy=1, write_enb=0; fifo_full drops after 3 cycles -> LAF, then LD. Packet completes with 16 total writes.
- pkt_valid falls while in FFS (low_pkt_valid=1), then fifo_full clears -> LAF, LP, CPE, DA.
- Header addr 3 -> stays in DA, write_enb_reg never asserts; the next header (addr 2) is accepted normally.
- soft_reset_2 pulse in LD with dest=2 -> DA next cycle. soft_reset_0 pulse with dest=2 -> no state change. resetn low mid-LD -> DA asynchronously, dest=0.
